// File: rtl/prod_accumulator.sv
// Group accumulator for unsigned multiplier products. Sums beats until in_last, then holds the result for the consumer.
// Define PROD_ACC_SATURATE_EN to clamp on overflow; by default the sum wraps modulo 2^ACC_W.
module prod_accumulator #(
    parameter int N     = 8,
    parameter int ACC_W = 2*N+8,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*N-1:0]     prod,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   acc_out,
    output logic [CNT_W-1:0]   beat_cnt,
    output logic               overflow
);

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ACC_W-1:0]   r_acc;
    logic [ACC_W-1:0]   w_acc_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_ovf;
    logic               w_ovf_nxt;
    logic               w_accept;
    logic [ACC_W:0]     w_sum;
    logic               w_carry;

`ifdef PROD_ACC_SATURATE_EN
    // Once clamped the group stays at full scale, even for zero-valued beats.
    function automatic logic [ACC_W-1:0] acc_update(input logic [ACC_W:0] sum,
                                                    input logic          clamped);
        if (sum[ACC_W] || clamped)
            return '1;
        return sum[ACC_W-1:0];
    endfunction
`else
    function automatic logic [ACC_W-1:0] acc_update(input logic [ACC_W:0] sum);
        return sum[ACC_W-1:0];
    endfunction
`endif

    function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] cnt);
        if (&cnt)
            return cnt;
        return cnt + CNT_W'(1);
    endfunction

    assign w_accept = in_valid && (r_state == ACCUM);
    assign w_sum    = {1'b0, r_acc} + {{(ACC_W+1-2*N){1'b0}}, prod};
    assign w_carry  = w_sum[ACC_W];

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_ovf_nxt   = r_ovf;
        case (r_state)
            ACCUM: begin
                if (w_accept) begin
`ifdef PROD_ACC_SATURATE_EN
                    w_acc_nxt = acc_update(w_sum, r_ovf);
`else
                    w_acc_nxt = acc_update(w_sum);
`endif
                    w_cnt_nxt = cnt_sat_inc(r_cnt);
                    w_ovf_nxt = r_ovf | w_carry;
                    if (in_last)
                        w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_acc_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_ovf_nxt   = 1'b0;
                    w_state_nxt = ACCUM;
                end
            end
            default: w_state_nxt = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ACCUM;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    assign in_ready  = (r_state == ACCUM);
    assign out_valid = (r_state == DONE);
    assign acc_out   = r_acc;
    assign beat_cnt  = r_cnt;
    assign overflow  = r_ovf;

endmodule

// File: doc/prod_accumulator.md
PROD_ACCUMULATOR -- requirements
Module: prod_accumulator

Interface
REQ-001 Parameter N, default 8, operand width of the upstream unsigned multiplier; product input is 2*N bits.
REQ-002 Parameter ACC_W, default 2*N+8, accumulator width; legal range 2*N <= ACC_W <= 64.
REQ-003 Parameter CNT_W, default 8, beat-counter width.
REQ-004 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 Port rst  input  1  reset, synchronous, active-high.
REQ-006 Port in_valid  input  1  product beat valid.
REQ-007 Port in_ready  output  1  accumulator can accept a beat.
REQ-008 Port prod  input  2*N  unsigned product from the multiplier.
REQ-009 Port in_last  input  1  marks final beat of a group; sampled with prod.
REQ-010 Port out_valid  output  1  accumulated result available.
REQ-011 Port out_ready  input  1  consumer accepts result.
REQ-012 Port acc_out  output  ACC_W  accumulated sum of the group.
REQ-013 Port beat_cnt  output  CNT_W  number of beats accepted in the group.
REQ-014 Port overflow  output  1  sticky per-group overflow flag.

Function
REQ-015 Two states: ACCUM and DONE; in_ready = (state==ACCUM); out_valid = (state==DONE).
REQ-016 Beat accepted when in_valid && in_ready on a rising edge; no other condition.
REQ-017 On accept: acc <= acc + zero-extended prod, computed at ACC_W+1 bits; beat_cnt <= beat_cnt+1, holding at 2^CNT_W-1 and never wrapping.
REQ-018 On accept with carry-out (bit ACC_W) set: overflow <= 1; overflow stays set until the group is released.
REQ-019 Accept with in_last=1: state -> DONE in the same edge; out_valid is asserted the cycle after the last beat is accepted (1-cycle latency).
REQ-020 acc_out, beat_cnt and overflow are registered and reflect all accepted beats, including the last, while out_valid=1.
REQ-021 In DONE, acc_out, beat_cnt and overflow hold stable until out_ready=1.
REQ-022 In DONE with out_ready=1: acc, beat_cnt and overflow clear to 0 and state -> ACCUM; in_ready is 1 on the next cycle.
REQ-023 In DONE, in_valid is ignored and prod is not summed; upstream holds its beat (in_ready=0).
REQ-024 in_last is ignored when in_valid=0 or in_ready=0.
REQ-025 A single-beat group (first beat carries in_last) yields acc_out=prod and beat_cnt=1.
REQ-026 prod=0 beats are accepted and counted normally.

Reset
REQ-027 rst=1 at a clock edge: state=ACCUM, acc=0, beat_cnt=0, overflow=0, from the next cycle in_ready=1 and out_valid=0.
REQ-028 rst has priority over every accept and release in the same cycle; reset mid-group or in DONE discards the partial or pending result.

Configuration
REQ-029 Macro PROD_ACC_SATURATE_EN selects overflow behaviour.
REQ-030 Defined: on carry-out, acc clamps to 2^ACC_W-1 and stays clamped for the rest of the group; overflow is set.
REQ-031 Undefined: acc wraps modulo 2^ACC_W; overflow is set.

Verification (N=8, CNT_W=8)
REQ-032 ACC_W=24: four beats of prod=0xFE01 with in_last on the fourth and out_ready=1 -> out_valid one cycle after the fourth accept, acc_out=0x03F804, beat_cnt=4, overflow=0.
REQ-033 ACC_W=18: five beats of 0xFE01 with in_last on the fifth -> with the macro undefined acc_out=0x0F605 and overflow=1; with PROD_ACC_SATURATE_EN defined acc_out=0x3FFFF and overflow=1.
REQ-034 Backpressure: result pending, out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0 and acc_out stable throughout; on out_ready=1 the next group starts from 0 and the held beat is accepted on the first ACCUM cycle.
REQ-035 Single beat prod=0x1234 with in_last -> acc_out=0x001234, beat_cnt=1.
REQ-036 Assert rst after two accepted beats (0x0100 each), then send one beat 0x0005 with in_last -> acc_out=0x000005, beat_cnt=1.
REQ-037 Gaps: in_valid toggled 1/0 across 3 beats (0x0001, 0x0002, 0x0003, last on third) -> acc_out=0x000006, beat_cnt=3.
